// File: rtl/paddle_ctrl_multi.sv
// paddle_ctrl_multi: per-frame paddle positions with hold-to-accelerate motion and saturating limits
module paddle_ctrl_multi #(
    parameter int NPAD        = 2,
    parameter int Y_W         = 10,
    parameter int MIN         = 30,
    parameter int MAX         = 329,
    parameter int CENTER      = 180,
    parameter int DELTA_MIN   = 1,
    parameter int DELTA_MAX   = 6,
    parameter int ACCEL_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                serve,
    input  logic [NPAD-1:0]     up,
    input  logic [NPAD-1:0]     down,
    output logic [NPAD*Y_W-1:0] y,
    output logic [NPAD-1:0]     at_min,
    output logic [NPAD-1:0]     at_max,
    output logic [NPAD-1:0]     moving
);
    localparam int SP_W = $clog2(DELTA_MAX + 1);
    localparam int HC_W = ACCEL_TICKS > 1 ? $clog2(ACCEL_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    for (genvar g = 0; g < NPAD; g++) begin : ch
        logic [Y_W-1:0]  y_q, y_d, y_mv;
        logic [Y_W:0]    sum, floor_lim;
        logic [SP_W-1:0] sp_q, sp_d, step;
        logic [HC_W-1:0] hc_q, hc_d;
        logic            hit;
        state_t          st_q, st_d, dir;

        // next-state: serve re-centres, tick moves/accelerates, otherwise hold
        always_comb begin
            dir       = (up[g] & ~down[g]) ? UP : (down[g] & ~up[g]) ? DOWN : IDLE;
            step      = (dir == st_q) ? sp_q : SP_W'(DELTA_MIN);
            sum       = {1'b0, y_q} + (Y_W+1)'(step);
            floor_lim = (Y_W+1)'(MIN) + (Y_W+1)'(step);
            y_mv      = (dir == UP) ? ((sum >= (Y_W+1)'(MAX)) ? Y_W'(MAX) : sum[Y_W-1:0])
                      : (({1'b0, y_q} <= floor_lim) ? Y_W'(MIN) : y_q - Y_W'(step));
            hit       = (y_mv == Y_W'(MIN)) || (y_mv == Y_W'(MAX));
            y_d       = y_q;
            st_d      = st_q;
            sp_d      = sp_q;
            hc_d      = hc_q;
            if (serve) begin
                y_d  = Y_W'(CENTER);
                st_d = IDLE;
                sp_d = SP_W'(DELTA_MIN);
                hc_d = '0;
            end else if (tick) begin
                if (dir == IDLE) begin
                    st_d = IDLE;
                    sp_d = SP_W'(DELTA_MIN);
                    hc_d = '0;
                end else begin
                    y_d  = y_mv;
                    st_d = dir;
                    if (dir != st_q || hit) begin
                        sp_d = SP_W'(DELTA_MIN);
                        hc_d = '0;
                    end else if (hc_q == HC_W'(ACCEL_TICKS - 1)) begin
                        hc_d = '0;
                        sp_d = (sp_q == SP_W'(DELTA_MAX)) ? sp_q : sp_q + 1'b1;
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
            end
        end

        // channel state registers with asynchronous reset to the serve values
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                y_q  <= Y_W'(CENTER);
                st_q <= IDLE;
                sp_q <= SP_W'(DELTA_MIN);
                hc_q <= '0;
            end else begin
                y_q  <= y_d;
                st_q <= st_d;
                sp_q <= sp_d;
                hc_q <= hc_d;
            end
        end

        assign y[g*Y_W +: Y_W] = y_q;
        assign at_min[g]       = (y_q == Y_W'(MIN));
        assign at_max[g]       = (y_q == Y_W'(MAX));
        assign moving[g]       = (st_q != IDLE);
    end
endmodule

// File: doc/paddle_ctrl_multi.md
Name: paddle_ctrl_multi

Overview:
Parametrised multi-paddle controller for the Pong-style game datapath. It holds the vertical position of NPAD paddles and updates them once per frame tick from up/down buttons. Motion accelerates while a button is held and saturates at configurable limits. A serve command re-centres all paddles. Outputs feed the renderer and the ball-collision logic.

Parameters:
NPAD, 2, number of paddle channels (≥1)
Y_W, 10, width of each position word
MIN, 30, lowest legal position
MAX, 329, highest legal position (MAX < 2^Y_W)
CENTER, 180, reset/serve position (MIN ≤ CENTER ≤ MAX)
DELTA_MIN, 1, step size on the first tick of a press and after any reset of speed (≥1)
DELTA_MAX, 6, speed ceiling (DELTA_MIN ≤ DELTA_MAX < MAX−MIN)
ACCEL_TICKS, 4, same-direction ticks per +1 speed increment (≥1)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
tick  in  1  one-cycle frame-update enable
serve  in  1  synchronous re-centre of all channels
up  in  NPAD  per-channel up button, already debounced (bit i = channel i)
down  in  NPAD  per-channel down button, already debounced
y  out  NPAD*Y_W  positions; channel i at bits [i*Y_W +: Y_W]
at_min  out  NPAD  y[i] == MIN
at_max  out  NPAD  y[i] == MAX
moving  out  NPAD  channel state != IDLE

Behaviour:
- Per-channel registers: y, state {IDLE, UP, DOWN}, speed (sized for DELTA_MAX), hold_cnt (sized for ACCEL_TICKS−1).
- Reset (reset_n=0, asynchronous): every y=CENTER, state=IDLE, speed=DELTA_MIN, hold_cnt=0. Outputs take these values without waiting for a clock edge. at_min, at_max and moving derive combinationally from the registers.
- Priority order each edge: serve > tick > hold.
- serve=1: all channels go to the reset values on the next edge, regardless of tick or buttons.
- No tick and no serve: all registers hold, so buttons are ignored between ticks.
- On tick, per channel, the requested direction is dir:
  - UP if up & ~down.
  - DOWN if down & ~up.
  - IDLE otherwise, including both buttons pressed.
- dir == IDLE: y holds; state=IDLE, speed=DELTA_MIN, hold_cnt=0.
- dir != IDLE and dir != state (new press or reversal):
  - step = DELTA_MIN.
  - state=dir, speed=DELTA_MIN, hold_cnt=0.
- dir == state (continued hold):
  - step = speed.
  - If hold_cnt == ACCEL_TICKS−1: hold_cnt=0 and speed = min(speed+1, DELTA_MAX).
  - Otherwise hold_cnt+1.
- Position arithmetic uses no wrap-around:
  - UP: computed in Y_W+1 bits; y = (y+step ≥ MAX) ? MAX : y+step.
  - DOWN: y = (y ≤ MIN+step) ? MIN : y−step, so there is no unsigned underflow.
- Limit hit: if a move lands on MIN or MAX, speed=DELTA_MIN and hold_cnt=0; state keeps dir. Continued pressing against the limit keeps y at the limit.
- Latency: y, flags and moving update on the clock edge that samples tick, so they are visible one cycle after tick.
- Channels are fully independent; no cross-channel interaction except serve.

Test Plan:
1. Release reset_n mid-cycle, no clock → all y=180, at_min=at_max=moving=0 immediately.
2. Hold up[0] for 10 ticks spaced 8 cycles apart (defaults) → steps 1,1,1,1,1,2,2,2,2,3; y0=196; y1 stays 180; moving=2'b01.
3. Hold up[0]=1 for 100 cycles with tick=0 → y0 stays 180, moving=0.
4. Hold down[1] for 60 ticks → y1 saturates at 30, at_min[1]=1 and stays; then release, press up[1] for 1 tick → y1=31 (speed reset).
5. Up[0] for 6 ticks (y0=187, speed 2), then one tick with up=down=1 → y0 holds 187, moving[0]=0; next up tick → y0=188.
6. While channels are moving, assert serve together with tick → next cycle all y=180, state IDLE; next up tick steps by 1.
